// File: rtl/prog_timer.sv
// -----------------------------------------------------------------------------
// prog_timer -- parametrised programmable timer
//
// This is a general timing source for downstream control FSMs. It counts
// prescaled ticks up (0 -> n) or down (n -> 0), either once or repeatedly,
// and it can be paused or aborted.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start_i       level; arms and runs the timer from IDLE
//   stop_i        synchronous abort to IDLE (highest priority)
//   pause_i       freezes counter and prescaler while high (RUN/PAUSE only)
//   mode_i        0 = one-shot, 1 = periodic (latched at start)
//   dir_i         0 = count up, 1 = count down (latched at start)
//   n_i           terminal count (latched at start)
//   prescale_i    tick divider; tick period is prescale_i+1 clocks
//   curr_time_q   registered current count
//   curr_end_q    registered end flag
//   busy_q        high in RUN or PAUSE
//   period_cnt_q  number of completed periods, saturating
//
// Optional build macro:
//   TIMER_PERIOD_CNT_EN  builds the completed-period counter. When it is
//                        not defined, period_cnt_q is tied to zero.
// -----------------------------------------------------------------------------
module prog_timer #(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8,
    parameter int PCNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               pause_i,
    input  logic               mode_i,
    input  logic               dir_i,
    input  logic [WIDTH-1:0]   n_i,
    input  logic [PRESC_W-1:0] prescale_i,
    output logic [WIDTH-1:0]   curr_time_q,
    output logic               curr_end_q,
    output logic               busy_q,
    output logic [PCNT_W-1:0]  period_cnt_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] prescale_q;
    logic [WIDTH-1:0]   n_q;
    logic               mode_q;
    logic               dir_q;

    logic               tick;
    logic [WIDTH-1:0]   term_val;
    logic [WIDTH-1:0]   start_val;
    logic [WIDTH-1:0]   next_time;
    logic               next_end;

    assign tick      = (presc_q == prescale_q);
    assign term_val  = dir_q ? '0 : n_q;
    assign start_val = dir_q ? n_q : '0;

    // The count only reaches the terminal value in periodic mode while in RUN,
    // because one-shot leaves RUN on that same edge. The next tick reloads it.
    always_comb begin
        next_time = curr_time_q;
        if (curr_time_q == term_val)
            next_time = start_val;
        else if (dir_q)
            next_time = curr_time_q - WIDTH'(1);
        else
            next_time = curr_time_q + WIDTH'(1);
    end

    // Covers n_q == 0 in periodic mode too: each reload lands on terminal again.
    assign next_end = (next_time == term_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            prescale_q  <= '0;
            n_q         <= '0;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            curr_time_q <= '0;
            curr_end_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else if (stop_i) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            prescale_q  <= '0;
            n_q         <= '0;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            curr_time_q <= '0;
            curr_end_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_q        <= n_i;
                        mode_q     <= mode_i;
                        dir_q      <= dir_i;
                        prescale_q <= prescale_i;
                        presc_q    <= '0;
                        if (n_i == '0) begin
                            // Zero-length period: terminal on the start edge.
                            curr_time_q <= '0;
                            curr_end_q  <= 1'b1;
                            busy_q      <= mode_i;
                            state_q     <= mode_i ? RUN : DONE;
                        end else begin
                            curr_time_q <= dir_i ? n_i : '0;
                            curr_end_q  <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause_i) begin
                        // A pending end pulse is dropped rather than frozen.
                        state_q    <= PAUSE;
                        curr_end_q <= 1'b0;
                    end else if (tick) begin
                        presc_q     <= '0;
                        curr_time_q <= next_time;
                        curr_end_q  <= next_end;
                        if (next_end && !mode_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        presc_q    <= presc_q + PRESC_W'(1);
                        curr_end_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (!pause_i)
                        state_q <= RUN;
                end
                DONE: begin
                    if (!start_i) begin
                        state_q     <= IDLE;
                        curr_time_q <= '0;
                        curr_end_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TIMER_PERIOD_CNT_EN
    logic pcnt_clear;
    logic pcnt_inc;

    function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] v);
        return (v == {PCNT_W{1'b1}}) ? v : v + PCNT_W'(1);
    endfunction

    // A terminal event is any edge on which the count becomes terminal:
    // the start edge itself when n_i is zero, or a terminal tick in RUN.
    assign pcnt_clear = stop_i || (state_q == IDLE && start_i);
    assign pcnt_inc   = !stop_i &&
                        ((state_q == IDLE && start_i && n_i == '0) ||
                         (state_q == RUN && !pause_i && tick && next_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            period_cnt_q <= '0;
        else if (pcnt_clear)
            period_cnt_q <= pcnt_inc ? PCNT_W'(1) : '0;
        else if (pcnt_inc)
            period_cnt_q <= sat_inc(period_cnt_q);
    end
`else
    assign period_cnt_q = '0;
`endif

endmodule

// File: tb/tb_prog_timer.sv
// -----------------------------------------------------------------------------
// tb_prog_timer -- self-checking bench for prog_timer.
// Expected outputs come from a closed-form model: after j advancing clocks
// since start the timer has seen j/(prescale+1) ticks, from which count,
// end flag, busy and completed periods follow arithmetically.
// -----------------------------------------------------------------------------
module tb_prog_timer;
    localparam int WIDTH   = 16;
    localparam int PRESC_W = 8;
    localparam int PCNT_W  = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_i = 1'b0;
    logic               stop_i = 1'b0;
    logic               pause_i = 1'b0;
    logic               mode_i = 1'b0;
    logic               dir_i = 1'b0;
    logic [WIDTH-1:0]   n_i = '0;
    logic [PRESC_W-1:0] prescale_i = '0;
    logic [WIDTH-1:0]   curr_time_q;
    logic               curr_end_q;
    logic               busy_q;
    logic [PCNT_W-1:0]  period_cnt_q;

    int n_cmp = 0;
    int n_bad = 0;

    prog_timer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W), .PCNT_W(PCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .pause_i(pause_i), .mode_i(mode_i), .dir_i(dir_i), .n_i(n_i),
        .prescale_i(prescale_i), .curr_time_q(curr_time_q),
        .curr_end_q(curr_end_q), .busy_q(busy_q), .period_cnt_q(period_cnt_q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: j = advancing clocks since the start edge.
    task automatic check_model(input string tag, input int j, input int n, input int p,
                               input bit m, input bit d, input bit paused);
        int  t, pos, pc;
        bit  e, b;
        t = j / (p + 1);
        if (!m) begin
            pos = (t < n) ? t : n;
            e   = (t >= n);
            b   = (t < n);
        end else begin
            pos = t % (n + 1);
            e   = (pos == n) && (j == 0 || (j % (p + 1)) == 0);
            b   = 1'b1;
        end
        pc = (m ? (t + 1) : (pos + 1)) / (n + 1);
        if (pc > 255) pc = 255;
        if (paused) e = 1'b0;
        chk({tag, ".time"}, 32'(curr_time_q), 32'(d ? n - pos : pos));
        chk({tag, ".end"}, 32'(curr_end_q), 32'(e));
        chk({tag, ".busy"}, 32'(busy_q), 32'(b));
`ifdef TIMER_PERIOD_CNT_EN
        chk({tag, ".pcnt"}, 32'(period_cnt_q), 32'(pc));
`else
        chk({tag, ".pcnt"}, 32'(period_cnt_q), 32'd0);
`endif
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".time"}, 32'(curr_time_q), 32'd0);
        chk({tag, ".end"}, 32'(curr_end_q), 32'd0);
        chk({tag, ".busy"}, 32'(busy_q), 32'd0);
        chk({tag, ".pcnt"}, 32'(period_cnt_q), 32'd0);
    endtask

    // Start a run, scramble the (already latched) config inputs every cycle,
    // then finish by dropping start (one-shot) or by stop (periodic).
    task automatic run_case(input string tag, input bit m, input bit d, input int n,
                            input int p, input int cycles);
        n_i = WIDTH'(n); prescale_i = PRESC_W'(p); mode_i = m; dir_i = d; start_i = 1'b1;
        step();
        check_model(tag, 0, n, p, m, d, 1'b0);
        for (int j = 1; j <= cycles; j++) begin
            n_i        = WIDTH'($urandom);
            prescale_i = PRESC_W'($urandom);
            dir_i      = 1'($urandom);
            mode_i     = 1'($urandom);
            if (m) start_i = 1'($urandom);
            step();
            check_model(tag, j, n, p, m, d, 1'b0);
        end
        if (!m) begin
            start_i = 1'b0;
            step();
            chk_idle({tag, ".drop"});
        end else begin
            start_i = 1'b0;
            stop_i  = 1'b1;
            step();
            chk_idle({tag, ".stop"});
            stop_i = 1'b0;
        end
    endtask

    initial begin
        // 1. reset, then idle with start low
        n_i = 16'd20;
        step();
        chk_idle("rst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_idle("idle");
        end

        // 2. one-shot up, n=20, prescale 0, start held 50 cycles
        run_case("oneshot_up", 1'b0, 1'b0, 20, 0, 50);

        // 3. periodic down, n=3, prescale 1
        run_case("per_down", 1'b1, 1'b1, 3, 1, 26);

        // 4. pause at count 4, stop at count 7
        n_i = 16'd10; prescale_i = '0; mode_i = 1'b0; dir_i = 1'b0; start_i = 1'b1;
        step();
        check_model("pause", 0, 10, 0, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            step();
            check_model("pause.pre", j, 10, 0, 1'b0, 1'b0, 1'b0);
        end
        pause_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_model("pause.hold", 4, 10, 0, 1'b0, 1'b0, 1'b1);
        end
        pause_i = 1'b0;
        step();
        check_model("pause.resume", 4, 10, 0, 1'b0, 1'b0, 1'b0);
        for (int j = 5; j <= 7; j++) begin
            step();
            check_model("pause.post", j, 10, 0, 1'b0, 1'b0, 1'b0);
        end
        stop_i = 1'b1;
        step();
        chk_idle("pause.stop");
        stop_i = 1'b0; start_i = 1'b0;
        step();
        chk_idle("pause.idle");

        // 5. n=0 one-shot
        run_case("n0_oneshot", 1'b0, 1'b0, 0, 0, 2);
        run_case("n0_periodic", 1'b1, 1'b1, 0, 2, 7);

        // largest terminal count, counting down
        run_case("max_down", 1'b1, 1'b1, 65535, 0, 3);

        // randomized configurations
        for (int k = 0; k < 8; k++) begin
            bit m, d;
            int n, p;
            m = 1'($urandom);
            d = 1'($urandom);
            n = int'($urandom_range(0, 12));
            p = int'($urandom_range(0, 3));
            run_case("rand", m, d, n, p, m ? int'($urandom_range(5, 60)) : n * (p + 1) + 3);
        end

        // 6. async reset mid-run at count 9
        n_i = 16'd30; prescale_i = '0; mode_i = 1'b0; dir_i = 1'b0; start_i = 1'b1;
        step();
        for (int j = 1; j <= 9; j++) step();
        check_model("areset.pre", 9, 30, 0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("areset.now");
        step();
        chk_idle("areset.held");
        start_i = 1'b0;
        rst_n = 1'b1;
        step();
        chk_idle("areset.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
Parametrised, programmable timer. It is the next generation of the single-width up-counting timer.
- Adds configurable width, a clock prescaler, up/down direction, one-shot/periodic mode, and pause/stop control.
- Sits beside the other sequential lab blocks as the general timing source for downstream control FSMs.

Parameters:
WIDTH, 16, width of terminal count n_i and of curr_time_q
PRESC_W, 8, width of prescale_i; tick period is prescale_i+1 clocks
PCNT_W, 8, width of period_cnt_q (optional feature)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  level; arms and runs the timer from IDLE
stop_i  input  1  synchronous abort to IDLE, highest priority
pause_i  input  1  freezes counter and prescaler while high
mode_i  input  1  0 = one-shot, 1 = periodic; latched at start
dir_i  input  1  0 = count up 0->n, 1 = count down n->0; latched at start
n_i  input  WIDTH  terminal count; latched at start
prescale_i  input  PRESC_W  tick divider; latched at start
curr_time_q  output  WIDTH  registered current count
curr_end_q  output  1  registered end flag
busy_q  output  1  high in RUN or PAUSE
period_cnt_q  output  PCNT_W  completed periods (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; curr_time_q=0, curr_end_q=0, busy_q=0, period_cnt_q=0.
  - Prescaler count=0; latched config=0.
- States: IDLE, RUN, PAUSE, DONE. Priority on every edge: stop_i > pause_i > start/tick.
- stop_i=1 in any state: IDLE next edge; all outputs take their reset values.
- IDLE, start_i=1:
  - Latch n_i, mode_i, dir_i, prescale_i.
  - curr_time_q = 0 (up) or n_i (down); busy_q=1; prescaler=0; go to RUN.
- Start with n_i=0: go straight to DONE (one-shot) or RUN (periodic), with curr_time_q=0 and curr_end_q=1 on the same edge.
- Tick: asserted in RUN when prescaler==prescale_q. At a tick the prescaler returns to 0; otherwise it increments. With prescale=0, every RUN cycle is a tick.
- RUN, non-terminal count, on a tick: curr_time_q ±1.
- Terminal value: n_q (up) or 0 (down). The edge on which curr_time_q becomes terminal also sets curr_end_q=1.
- One-shot, at terminal:
  - Go to DONE; busy_q=0; curr_time_q holds the terminal value.
  - curr_end_q stays 1 while start_i=1.
  - DONE with start_i=0: IDLE next edge; curr_time_q=0, curr_end_q=0.
- Periodic, at terminal:
  - curr_end_q is a one-cycle pulse.
  - The tick after terminal reloads the start value (0 or n_q). Period = n_q+1 ticks.
  - start_i is ignored in RUN; only stop_i exits.
- pause_i=1 in RUN: go to PAUSE; counter, prescaler and curr_end_q freeze (a pending end pulse is cleared to 0); busy_q stays 1.
- pause_i=0 in PAUSE: back to RUN; the count resumes exactly where it stopped.
- pause_i in IDLE or DONE: ignored.
- n_i, dir_i, mode_i and prescale_i changes after start have no effect until the next start.
- Arithmetic: unsigned WIDTH bits; the counter never wraps past terminal. n_i = 2^WIDTH-1 is legal.
- One-shot up, prescale=0, start sampled at edge k: curr_time_q=1..n at edges k+1..k+n; curr_end_q=1 from edge k+n.

Optional Feature:
Macro TIMER_PERIOD_CNT_EN.
- Defined: period_cnt_q increments on every terminal event, saturating at 2^PCNT_W-1. Cleared by reset, stop_i and the IDLE->RUN start.
- Undefined: period_cnt_q is tied to 0 and no counter logic is built.

Test Plan:
1. Reset, start_i=0, n_i=20 for 20 cycles -> curr_time_q=0, curr_end_q=0, busy_q=0 every cycle.
2. One-shot up, n=20, prescale=0, start held 50 cycles -> curr_time_q counts 0..20, curr_end_q=1 from the cycle it reads 20, stays 20/1; drop start -> 0/0 next cycle.
3. Periodic down, n=3, prescale=1 -> curr_time_q 3,3,2,2,1,1,0,0,3..., curr_end_q one-cycle pulse per period; with TIMER_PERIOD_CNT_EN, period_cnt_q=1,2,3.
4. One-shot up, n=10: pause for 5 cycles at count 4, then stop_i at count 7 -> count holds 4 while paused, resumes 5,6,7, then IDLE with all outputs 0.
5. n_i=0 one-shot start -> curr_end_q=1, curr_time_q=0 on the first edge, busy_q=0.
6. Async reset mid-RUN at count 9 -> outputs go to 0 immediately without waiting for a clock edge.
